// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage -- execute stage of the 5-stage ARM pipeline.
//
// Builds the second ALU operand (Val2), runs the ALU, computes the branch
// target and owns the NZCV status register that feeds back to decode.
// Results are captured into the EX/MEM boundary one clock later. A freeze
// from the memory side holds every registered output and the status register.
//
// Optional feature: define FORWARDING_EN to put a forwarding mux in front of
// both operands (adds ports sel_src1, sel_src2, MEM_fwd, WB_fwd).
//
// Ports:
//   clk, rst (async, active-low), freeze
//   ID/EX inputs : WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN,
//                  EXE_CMD_IN[3:0], PC_IN, Val_Rn_IN, Val_Rm_IN,
//                  Shift_operand_IN[11:0], Signed_imm_24_IN[23:0],
//                  Dest_IN[3:0], SR_IN[3:0] = {N,Z,C,V}
//   combinational: Branch_taken, Branch_Address
//   registered   : SR, WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, ST_val, Dest
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             WB_EN_IN,
    input  logic             MEM_R_EN_IN,
    input  logic             MEM_W_EN_IN,
    input  logic             B_IN,
    input  logic             S_IN,
    input  logic             imm_IN,
    input  logic [3:0]       EXE_CMD_IN,
    input  logic [WIDTH-1:0] PC_IN,
    input  logic [WIDTH-1:0] Val_Rn_IN,
    input  logic [WIDTH-1:0] Val_Rm_IN,
    input  logic [11:0]      Shift_operand_IN,
    input  logic [23:0]      Signed_imm_24_IN,
    input  logic [3:0]       Dest_IN,
    input  logic [3:0]       SR_IN,
    output logic             Branch_taken,
    output logic [WIDTH-1:0] Branch_Address,
    output logic [3:0]       SR,
    output logic             WB_EN,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic [WIDTH-1:0] ALU_Res,
    output logic [WIDTH-1:0] ST_val,
    output logic [3:0]       Dest
`ifdef FORWARDING_EN
    ,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [WIDTH-1:0] MEM_fwd,
    input  logic [WIDTH-1:0] WB_fwd
`endif
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [5:0] W6 = 6'(WIDTH);

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rn, rm;

`ifdef FORWARDING_EN
    // 00 and 11 both take the register-file value.
    always_comb begin
        case (sel_src1)
            2'b01:   rn = MEM_fwd;
            2'b10:   rn = WB_fwd;
            default: rn = Val_Rn_IN;
        endcase
        case (sel_src2)
            2'b01:   rm = MEM_fwd;
            2'b10:   rm = WB_fwd;
            default: rm = Val_Rm_IN;
        endcase
    end
`else
    assign rn = Val_Rn_IN;
    assign rm = Val_Rm_IN;
`endif

    // ------------------------------------------------------------------
    // Val2 generation
    // ------------------------------------------------------------------
    logic             mem_op;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] imm_base;
    logic [4:0]       imm_rot;
    logic [4:0]       sh_amt;

    assign mem_op   = MEM_R_EN_IN | MEM_W_EN_IN;
    assign imm_base = {{(WIDTH-8){1'b0}}, Shift_operand_IN[7:0]};
    assign imm_rot  = {Shift_operand_IN[11:8], 1'b0};
    assign sh_amt   = Shift_operand_IN[11:7];

    // Rotates use (x >> n) | (x << (W-n)); for n==0 the left term shifts
    // by the full width and vanishes, so the value passes unchanged.
    always_comb begin
        val2 = rm;
        if (mem_op) begin
            val2 = {{(WIDTH-12){1'b0}}, Shift_operand_IN};
        end else if (imm_IN) begin
            val2 = (imm_base >> imm_rot) | (imm_base << (W6 - {1'b0, imm_rot}));
        end else begin
            case (Shift_operand_IN[6:5])
                2'b00: val2 = rm << sh_amt;
                2'b01: val2 = rm >> sh_amt;
                2'b10: val2 = WIDTH'($signed(rm) >>> sh_amt);
                2'b11: val2 = (rm >> sh_amt) | (rm << (W6 - {1'b0, sh_amt}));
            endcase
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [3:0]       alu_cmd;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_in, c_out, v_out, flag_ok;

    assign alu_cmd = mem_op ? CMD_ADD : EXE_CMD_IN;
    assign c_in    = SR_IN[1];

    // Subtraction is done as a + ~b + carry so the carry-out is directly
    // the ARM "not borrow" flag.
    always_comb begin
        sum     = '0;
        res     = '0;
        c_out   = SR_IN[1];
        v_out   = SR_IN[0];
        flag_ok = 1'b1;
        case (alu_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum   = {1'b0, rn} + {1'b0, val2}
                      + {{WIDTH{1'b0}}, (alu_cmd == CMD_ADC) & c_in};
                res   = sum[WIDTH-1:0];
                c_out = sum[WIDTH];
                v_out = (rn[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != rn[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum   = {1'b0, rn} + {1'b0, ~val2}
                      + {{WIDTH{1'b0}}, (alu_cmd == CMD_SUB) | c_in};
                res   = sum[WIDTH-1:0];
                c_out = sum[WIDTH];
                v_out = (rn[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != rn[WIDTH-1]);
            end
            CMD_AND: res = rn & val2;
            CMD_ORR: res = rn | val2;
            CMD_EOR: res = rn ^ val2;
            default: flag_ok = 1'b0;   // unknown op: result 0, no flag write
        endcase
    end

    logic [3:0] new_sr;
    assign new_sr = {res[WIDTH-1], (res == '0), c_out, v_out};

    // ------------------------------------------------------------------
    // Branch target (combinational, tracks inputs even while frozen)
    // ------------------------------------------------------------------
    assign Branch_taken   = B_IN;
    assign Branch_Address = PC_IN
                          + {{(WIDTH-26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

    // ------------------------------------------------------------------
    // Status register and EX/MEM registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SR <= 4'b0000;
        end else if (!freeze && S_IN && flag_ok) begin
            SR <= new_sr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            ALU_Res  <= '0;
            ST_val   <= '0;
            Dest     <= '0;
        end else if (!freeze) begin
            WB_EN    <= WB_EN_IN;
            MEM_R_EN <= MEM_R_EN_IN;
            MEM_W_EN <= MEM_W_EN_IN;
            ALU_Res  <= res;
            ST_val   <= rm;
            Dest     <= Dest_IN;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN, SR_IN;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic [3:0]  SR;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_Res, ST_val;
    logic [3:0]  Dest;
`ifdef FORWARDING_EN
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] MEM_fwd, WB_fwd;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .B_IN(B_IN), .S_IN(S_IN), .imm_IN(imm_IN), .EXE_CMD_IN(EXE_CMD_IN),
        .PC_IN(PC_IN), .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN),
        .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
        .Dest_IN(Dest_IN), .SR_IN(SR_IN),
        .Branch_taken(Branch_taken), .Branch_Address(Branch_Address), .SR(SR),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .ST_val(ST_val), .Dest(Dest)
`ifdef FORWARDING_EN
        , .sel_src1(sel_src1), .sel_src2(sel_src2), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s, input logic imm,
                         input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] op, input logic [3:0] sr_in);
        EXE_CMD_IN = cmd; S_IN = s; imm_IN = imm;
        Val_Rn_IN = rn; Val_Rm_IN = rm; Shift_operand_IN = op; SR_IN = sr_in;
        WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0; B_IN = 1'b0;
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0;
        WB_EN_IN = 0; MEM_R_EN_IN = 0; MEM_W_EN_IN = 0; B_IN = 0; S_IN = 0; imm_IN = 0;
        EXE_CMD_IN = 0; PC_IN = 0; Val_Rn_IN = 0; Val_Rm_IN = 0;
        Shift_operand_IN = 0; Signed_imm_24_IN = 0; Dest_IN = 4'd3; SR_IN = 0;
`ifdef FORWARDING_EN
        sel_src1 = 2'b00; sel_src2 = 2'b00; MEM_fwd = 0; WB_fwd = 0;
`endif
        #2;
        chk("reset_alu", ALU_Res, 32'h0);
        chk("reset_sr", {28'h0, SR}, 32'h0);
        chk("reset_ctrl", {29'h0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'h0);
        chk("reset_dest", {28'h0, Dest}, 32'h0);
        tick();
        rst = 1'b1;

        // ADD immediate with signed overflow
        drive(4'b0010, 1, 1, 32'h7FFFFFFF, 32'h0, 12'h001, 4'b0000);
        tick();
        chk("add_ovf_res", ALU_Res, 32'h80000000);
        chk("add_ovf_sr", {28'h0, SR}, 32'h9);
        chk("add_wb_en", {31'h0, WB_EN}, 32'h1);
        chk("add_dest", {28'h0, Dest}, 32'h3);

        // SUB equal operands, then AND without S leaves SR alone
        drive(4'b0100, 1, 0, 32'h5, 32'h5, 12'h000, 4'b0000);
        tick();
        chk("sub_eq_res", ALU_Res, 32'h0);
        chk("sub_eq_sr", {28'h0, SR}, 32'h6);
        drive(4'b0110, 0, 0, 32'hF0, 32'h3C, 12'h000, 4'b0000);
        tick();
        chk("and_res", ALU_Res, 32'h30);
        chk("and_sr_hold", {28'h0, SR}, 32'h6);

        // Immediate rotate and register shifts through MOV
        drive(4'b0001, 0, 1, 32'h0, 32'h0, 12'h4FF, 4'b0000);
        tick();
        chk("mov_imm_ror8", ALU_Res, 32'hFF000000);
        drive(4'b0001, 0, 0, 32'h0, 32'h80000000, 12'h240, 4'b0000);
        tick();
        chk("mov_asr4", ALU_Res, 32'hF8000000);
        drive(4'b0001, 0, 0, 32'h0, 32'h00000001, 12'h200, 4'b0000);
        tick();
        chk("mov_lsl4", ALU_Res, 32'h00000010);
        drive(4'b0001, 0, 0, 32'h0, 32'h80000000, 12'h220, 4'b0000);
        tick();
        chk("mov_lsr4", ALU_Res, 32'h08000000);
        drive(4'b0001, 0, 0, 32'h0, 32'h00000001, 12'h260, 4'b0000);
        tick();
        chk("mov_ror4", ALU_Res, 32'h10000000);
        drive(4'b0001, 0, 0, 32'h0, 32'h80000001, 12'h040, 4'b0000);
        tick();
        chk("mov_asr0", ALU_Res, 32'h80000001);
        drive(4'b0001, 0, 0, 32'h0, 32'h80000001, 12'h060, 4'b0000);
        tick();
        chk("mov_ror0", ALU_Res, 32'h80000001);

        // Branch target is combinational
        B_IN = 1'b1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'h0, Branch_taken}, 32'h1);
        chk("br_addr_neg", Branch_Address, 32'h000000F8);
        PC_IN = 32'h1000; Signed_imm_24_IN = 24'h000010;
        #1;
        chk("br_addr_pos", Branch_Address, 32'h00001040);
        B_IN = 1'b0;

        // MVN with S: N/Z from result, C/V from SR_IN
        drive(4'b1001, 1, 1, 32'h0, 32'h0, 12'h000, 4'b0011);
        tick();
        chk("mvn_res", ALU_Res, 32'hFFFFFFFF);
        chk("mvn_sr", {28'h0, SR}, 32'hB);

        // ADD wrap
        drive(4'b0010, 1, 1, 32'hFFFFFFFF, 32'h0, 12'h001, 4'b0000);
        tick();
        chk("add_wrap_res", ALU_Res, 32'h0);
        chk("add_wrap_sr", {28'h0, SR}, 32'h6);

        // Freeze across an S=1 ADC, carry-in 1
        drive(4'b0011, 1, 1, 32'd10, 32'h0, 12'h005, 4'b0010);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_alu_hold", ALU_Res, 32'h0);
            chk("frz_sr_hold", {28'h0, SR}, 32'h6);
        end
        freeze = 1'b0;
        tick();
        chk("adc_res", ALU_Res, 32'd16);
        chk("adc_sr", {28'h0, SR}, 32'h0);

        // SBC with C=0: 10 - 3 - 1
        drive(4'b0101, 1, 1, 32'd10, 32'h0, 12'h003, 4'b0000);
        tick();
        chk("sbc_res", ALU_Res, 32'd6);
        chk("sbc_sr", {28'h0, SR}, 32'h2);

        // SUB signed overflow
        drive(4'b0100, 1, 1, 32'h80000000, 32'h0, 12'h001, 4'b0000);
        tick();
        chk("sub_ovf_res", ALU_Res, 32'h7FFFFFFF);
        chk("sub_ovf_sr", {28'h0, SR}, 32'h3);

        // Unknown code: result 0, flags untouched
        drive(4'b0000, 1, 1, 32'h1234, 32'h0, 12'h001, 4'b1111);
        tick();
        chk("unk_res", ALU_Res, 32'h0);
        chk("unk_sr", {28'h0, SR}, 32'h3);

        // ORR / EOR
        drive(4'b0111, 0, 0, 32'hF0, 32'h0F, 12'h000, 4'b0000);
        tick();
        chk("orr_res", ALU_Res, 32'hFF);
        drive(4'b1000, 0, 0, 32'hFF, 32'h0F, 12'h000, 4'b0000);
        tick();
        chk("eor_res", ALU_Res, 32'hF0);

        // Store: forced ADD with the raw 12-bit operand, not the rotate
        drive(4'b0001, 0, 1, 32'h1000, 32'hDEAD, 12'h804, 4'b0000);
        WB_EN_IN = 1'b0; MEM_W_EN_IN = 1'b1; Dest_IN = 4'd7;
        tick();
        chk("st_addr", ALU_Res, 32'h1804);
        chk("st_val", ST_val, 32'hDEAD);
        chk("st_ctrl", {29'h0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'h1);
        chk("st_dest", {28'h0, Dest}, 32'h7);

`ifdef FORWARDING_EN
        drive(4'b0010, 0, 1, 32'd99, 32'h77, 12'h003, 4'b0000);
        sel_src1 = 2'b01; MEM_fwd = 32'd10; sel_src2 = 2'b10; WB_fwd = 32'h55;
        tick();
        chk("fwd_mem_add", ALU_Res, 32'd13);
        chk("fwd_wb_st", ST_val, 32'h55);
        sel_src1 = 2'b00; sel_src2 = 2'b00;
`endif

        // Asynchronous reset mid-stream, no clock edge needed
        drive(4'b0010, 1, 1, 32'h7FFFFFFF, 32'h0, 12'h001, 4'b0000);
        tick();
        chk("pre_rst_sr", {28'h0, SR}, 32'h9);
        rst = 1'b0;
        #1;
        chk("mid_rst_alu", ALU_Res, 32'h0);
        chk("mid_rst_sr", {28'h0, SR}, 32'h0);
        chk("mid_rst_st", ST_val, 32'h0);
        chk("mid_rst_ctrl", {28'h0, WB_EN, MEM_R_EN, MEM_W_EN, |Dest}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
